uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter byte stream (AXI-Stream, 8-bit) between NUM_REQ AXI-Stream byte sources.
- Round-robin arbitration with packet lock: a granted source holds the UART until its tlast beat, or until a stall timeout.
- Sits between software/hardware message producers and the axis_uart TX input. The transmitter's divider and parity are configured elsewhere.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- DATA_WIDTH, 8, byte width; must equal uart_pkg DATA_WIDTH.
- TIMEOUT_CYCLES, 1024, cycles with no valid beat from the granted source before forced release; 0 disables the timeout.

Ports:
- clk_i  in  1  system clock
- arstn_i  in  1  asynchronous active-low reset
- req_en_i  in  NUM_REQ  per-requester enable mask, sampled only at arbitration
- s_axis_tdata_i  in  NUM_REQ*DATA_WIDTH  packed source bytes, requester k at [k*8 +: 8]
- s_axis_tvalid_i  in  NUM_REQ  source valid
- s_axis_tlast_i  in  NUM_REQ  last byte of a source message
- s_axis_tready_o  out  NUM_REQ  source ready
- m_axis_tdata_o  out  DATA_WIDTH  byte to UART TX
- m_axis_tvalid_o  out  1  valid to UART TX
- m_axis_tready_i  in  1  UART TX ready
- m_axis_tid_o  out  $clog2(NUM_REQ)  index of the current grant holder
- busy_o  out  1  a grant is held
- timeout_o  out  1  one-cycle pulse on forced release

Behaviour:
- Reset (asynchronous, arstn_i low):
  - state=ARB_IDLE, grant=0, last_grant=NUM_REQ-1, timeout counter=0.
  - All s_axis_tready_o=0, m_axis_tvalid_o=0, m_axis_tdata_o=0, m_axis_tid_o=0, busy_o=0, timeout_o=0.
  - Reset mid-packet abandons the packet; no partial state survives.
- ARB_IDLE:
  - Candidate set = s_axis_tvalid_i & req_en_i.
  - If the set is non-empty: grant = first set bit searching upward from last_grant+1 with wrap (index NUM_REQ-1 wraps to 0). Register grant; last_grant <= grant; go to ARB_BUSY next cycle.
  - All tready=0 and m_axis_tvalid_o=0 in ARB_IDLE, so there is 1 bubble cycle per packet.
- ARB_BUSY:
  - Combinational passthrough: m_axis_tvalid_o = s_axis_tvalid_i[grant]; m_axis_tdata_o = selected byte; s_axis_tready_o[grant] = m_axis_tready_i; other readies = 0.
  - m_axis_tid_o = grant; busy_o = 1.
  - Handshake with s_axis_tlast_i[grant]=1: return to ARB_IDLE next cycle.
  - Clearing req_en_i of the holder mid-packet does not revoke the grant.
- Timeout:
  - Counter increments on every ARB_BUSY cycle with s_axis_tvalid_i[grant]=0 and clears on any cycle where it is 1.
  - When the counter reaches TIMEOUT_CYCLES-1 with valid still low: go to ARB_IDLE, timeout_o=1 for that transition cycle, counter cleared.
  - The rest of the stalled packet is delivered after a later re-grant, with no framing recovery.
  - Valid-low at the same cycle the limit is reached means the timeout wins. If valid is high that cycle, there is no timeout.
- m_axis_tvalid_o never depends on m_axis_tready_i (AXI rule); sources must hold data until accepted.
- Counter width = $clog2(TIMEOUT_CYCLES+1). It saturates and never wraps.

Optional Feature:
- Macro UART_TX_ARB_STATS_EN.
- Defined: adds output stat_bytes_o (NUM_REQ*32), a per-requester count of accepted bytes. Counters wrap modulo 2^32, reset to 0, and increment on each m handshake for the grant holder. Also adds output stat_timeouts_o (NUM_REQ*16), per-requester forced-release counts that saturate at 16'hFFFF.
- Undefined: neither port nor their counters exist; behaviour is otherwise identical.

Decomposition:
- uart_pkg additions:
  - typedef enum logic {ARB_IDLE, ARB_BUSY} uart_arb_state_e.
  - localparam int ARB_MAX_REQ = 16.
  - localparam int ARB_STAT_WIDTH = 32.
- Sub-module rr_arbiter: combinational round-robin picker.
  - Inputs: req vector, last_grant pointer. Outputs: grant index, any_req.
  - Reusable for other shared resources.

Test Plan:
- Reset then req0 sends 3 bytes 0x41,0x42,0x43 (tlast on 0x43), m_tready=1: bytes appear in order, tid=0; busy drops 1 cycle after tlast; readies=0 during reset.
- req1 and req3 both valid with 2-byte packets: order is req1 packet then req3 packet; next contention among 0,1,3 grants req3→req0 correctly by wrap (last_grant=3 → 0 first).
- m_tready toggled 1/0 each cycle during a 4-byte packet: 4 handshakes only, no duplicated or dropped byte, tdata stable while stalled.
- TIMEOUT_CYCLES=8, req2 sends 1 byte without tlast then drops valid: timeout_o pulses exactly 8 cycles later, req0 pending is then granted; with valid re-asserted at cycle 7, no timeout.
- req_en_i=4'b1101 with all valid: req1 never granted; clearing en bit of the holder mid-packet still completes its packet.
- With UART_TX_ARB_STATS_EN: after scenarios 1 and 4, stat_bytes_o[0]=3, stat_bytes_o[2]=1, stat_timeouts_o[2]=1.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART types and limits used by the TX byte-stream arbiter.
package uart_pkg;
  localparam int DATA_WIDTH     = 8;
  localparam int ARB_MAX_REQ    = 16;
  localparam int ARB_STAT_WIDTH = 32;

  typedef enum logic {ARB_IDLE, ARB_BUSY} uart_arb_state_e;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: lowest request index strictly after last_grant_i, with wrap.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDW-1:0]     last_grant_i,
  output logic [IDW-1:0]     grant_o,
  output logic               any_req_o
);

  // Walk from the farthest offset down so the nearest requester is written last and wins.
  always_comb begin
    int             t;
    logic [IDW-1:0] idx;
    grant_o   = last_grant_i;
    any_req_o = 1'b0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      t = int'(last_grant_i) + i;
      if (t >= NUM_REQ) t = t - NUM_REQ;
      idx = IDW'(t);
      if (req_i[idx]) begin
        grant_o   = idx;
        any_req_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-locked round-robin mux of NUM_REQ AXI-Stream byte sources onto one UART TX stream; one idle bubble per packet.
// Stalled holders are released after TIMEOUT_CYCLES; UART_TX_ARB_STATS_EN adds per-source byte/timeout counters.
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_WIDTH     = uart_pkg::DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                          clk_i,
  input  logic                          arstn_i,
  input  logic [NUM_REQ-1:0]            req_en_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] s_axis_tdata_i,
  input  logic [NUM_REQ-1:0]            s_axis_tvalid_i,
  input  logic [NUM_REQ-1:0]            s_axis_tlast_i,
  output logic [NUM_REQ-1:0]            s_axis_tready_o,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata_o,
  output logic                          m_axis_tvalid_o,
  input  logic                          m_axis_tready_i,
  output logic [$clog2(NUM_REQ)-1:0]    m_axis_tid_o,
  output logic                          busy_o,
`ifdef UART_TX_ARB_STATS_EN
  output logic [NUM_REQ*uart_pkg::ARB_STAT_WIDTH-1:0] stat_bytes_o,
  output logic [NUM_REQ*16-1:0]                       stat_timeouts_o,
`endif
  output logic                          timeout_o
);
  import uart_pkg::uart_arb_state_e;
  import uart_pkg::ARB_IDLE;
  import uart_pkg::ARB_BUSY;

  localparam int IDW    = $clog2(NUM_REQ);
  localparam int CNT_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int TO_LIM = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [CNT_W-1:0] TO_LIM_C = CNT_W'(TO_LIM);

  uart_arb_state_e       state;
  logic [IDW-1:0]        grant, last_grant, pick;
  logic                  any_req, busy, sel_vld, sel_last, m_hs, to_hit;
  logic [CNT_W-1:0]      to_cnt;
  logic [DATA_WIDTH-1:0] sel_dat;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IDW(IDW)) u_rr (
    .req_i        (s_axis_tvalid_i & req_en_i),
    .last_grant_i (last_grant),
    .grant_o      (pick),
    .any_req_o    (any_req)
  );

  assign busy     = (state == ARB_BUSY);
  assign sel_vld  = s_axis_tvalid_i[grant];
  assign sel_last = s_axis_tlast_i[grant];

  always_comb begin
    sel_dat = '0;
    for (int k = 0; k < NUM_REQ; k++)
      if (grant == IDW'(k)) sel_dat = s_axis_tdata_i[k*DATA_WIDTH +: DATA_WIDTH];
  end

  always_comb begin
    s_axis_tready_o = '0;
    if (busy) s_axis_tready_o[grant] = m_axis_tready_i;
  end

  assign m_axis_tvalid_o = busy & sel_vld;
  assign m_axis_tdata_o  = busy ? sel_dat : '0;
  assign m_axis_tid_o    = busy ? grant : '0;
  assign busy_o          = busy;
  assign m_hs            = m_axis_tvalid_o & m_axis_tready_i;
  // A valid beat on the limit cycle rescues the grant; only a still-idle holder is evicted.
  assign to_hit = (TIMEOUT_CYCLES > 0) && busy && !sel_vld && (to_cnt == TO_LIM_C);

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state      <= ARB_IDLE;
      grant      <= '0;
      last_grant <= IDW'(NUM_REQ - 1);
      to_cnt     <= '0;
      timeout_o  <= 1'b0;
    end else begin
      timeout_o <= 1'b0;
      case (state)
        ARB_IDLE: begin
          to_cnt <= '0;
          if (any_req) begin
            grant      <= pick;
            last_grant <= pick;
            state      <= ARB_BUSY;
          end
        end
        ARB_BUSY: begin
          if (to_hit) begin
            state     <= ARB_IDLE;
            timeout_o <= 1'b1;
            to_cnt    <= '0;
          end else begin
            if (sel_vld)             to_cnt <= '0;
            else if (to_cnt != '1)   to_cnt <= to_cnt + CNT_W'(1);
            if (m_hs && sel_last)    state  <= ARB_IDLE;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

`ifdef UART_TX_ARB_STATS_EN
  localparam int SW = uart_pkg::ARB_STAT_WIDTH;

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      stat_bytes_o    <= '0;
      stat_timeouts_o <= '0;
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (m_hs && grant == IDW'(k))
          stat_bytes_o[k*SW +: SW] <= stat_bytes_o[k*SW +: SW] + SW'(1);
        if (to_hit && grant == IDW'(k) && stat_timeouts_o[k*16 +: 16] != 16'hFFFF)
          stat_timeouts_o[k*16 +: 16] <= stat_timeouts_o[k*16 +: 16] + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter (NUM_REQ=4, TIMEOUT_CYCLES=8): queued source beats, expected-beat queue, negedge monitor.
module tb_uart_tx_arbiter;
  localparam int N = 4;

  typedef struct {logic [7:0] dat; logic last; int gap;} src_beat_t;
  typedef struct {int tid; logic [7:0] dat; logic last;} exp_beat_t;

  logic         clk = 1'b0;
  logic         arstn;
  logic [N-1:0] req_en;
  logic [N*8-1:0] s_tdata;
  logic [N-1:0] s_tvalid, s_tlast, s_tready;
  logic [7:0]   m_tdata;
  logic         m_tvalid, m_tready;
  logic [1:0]   m_tid;
  logic         busy, tmo;
`ifdef UART_TX_ARB_STATS_EN
  logic [N*32-1:0] stat_bytes;
  logic [N*16-1:0] stat_tos;
`endif

  uart_tx_arbiter #(.NUM_REQ(N), .DATA_WIDTH(8), .TIMEOUT_CYCLES(8)) dut (
    .clk_i(clk), .arstn_i(arstn), .req_en_i(req_en),
    .s_axis_tdata_i(s_tdata), .s_axis_tvalid_i(s_tvalid), .s_axis_tlast_i(s_tlast),
    .s_axis_tready_o(s_tready), .m_axis_tdata_o(m_tdata), .m_axis_tvalid_o(m_tvalid),
    .m_axis_tready_i(m_tready), .m_axis_tid_o(m_tid), .busy_o(busy),
`ifdef UART_TX_ARB_STATS_EN
    .stat_bytes_o(stat_bytes), .stat_timeouts_o(stat_tos),
`endif
    .timeout_o(tmo)
  );

  always #5 clk = ~clk;

  src_beat_t src_q [N][$];
  exp_beat_t exp_q [$];
  int  n_cmp = 0, n_err = 0;
  int  cyc = 0, last_hs_cyc = 0, to_seen = 0;
  bit  tog = 1'b0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic src(int k, logic [7:0] d, logic l, int g);
    src_beat_t b;
    b.dat = d; b.last = l; b.gap = g;
    src_q[k].push_back(b);
  endtask

  task automatic expb(int t, logic [7:0] d, logic l);
    exp_beat_t e;
    e.tid = t; e.dat = d; e.last = l;
    exp_q.push_back(e);
  endtask

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #3;
  endtask

  task automatic drain(string nm);
    int n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      step(1);
      n++;
    end
    chk({nm, "_beats_outstanding"}, exp_q.size(), 0);
    exp_q.delete();
    step(12);
  endtask

  // Source driver: samples handshakes at negedge, advances its queues just after posedge.
  initial begin
    bit src_hs [N];
    bit loaded [N];
    int gap_left [N];
    s_tvalid = '0; s_tlast = '0; s_tdata = '0; m_tready = 1'b1;
    for (int k = 0; k < N; k++) begin loaded[k] = 0; gap_left[k] = 0; end
    forever begin
      @(negedge clk);
      for (int k = 0; k < N; k++) src_hs[k] = s_tvalid[k] & s_tready[k];
      @(posedge clk);
      cyc++;
      #1;
      for (int k = 0; k < N; k++) begin
        if (src_hs[k]) begin
          src_q[k].delete(0);
          loaded[k] = 0;
        end
        s_tvalid[k] = 1'b0; s_tlast[k] = 1'b0; s_tdata[k*8 +: 8] = 8'h00;
        if (src_q[k].size() > 0) begin
          if (!loaded[k]) begin gap_left[k] = src_q[k][0].gap; loaded[k] = 1; end
          if (gap_left[k] > 0) gap_left[k]--;
          else begin
            s_tvalid[k] = 1'b1;
            s_tlast[k]  = src_q[k][0].last;
            s_tdata[k*8 +: 8] = src_q[k][0].dat;
          end
        end
      end
      m_tready = tog ? ~m_tready : 1'b1;
    end
  end

  // Monitor: pops the expected queue on every output handshake.
  initial begin
    exp_beat_t e;
    bit busy_chk = 0, stall_pend = 0;
    logic [7:0] stall_dat = 8'h00;
    forever begin
      @(negedge clk);
      if (busy_chk) begin chk("busy_after_tlast", busy, 0); busy_chk = 0; end
      if (stall_pend) begin
        chk("stall_hold_vld", m_tvalid, 1);
        chk("stall_hold_dat", m_tdata, stall_dat);
        stall_pend = 0;
      end
      if (m_tvalid && !m_tready) begin stall_pend = 1; stall_dat = m_tdata; end
      if (m_tvalid && m_tready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_beat: got tid=%0d dat=0x%0h, expected no beat (t=%0t)", m_tid, m_tdata, $time);
        end else begin
          e = exp_q.pop_front();
          chk("beat_tid", m_tid, e.tid);
          chk("beat_dat", m_tdata, e.dat);
          if (e.last) busy_chk = 1;
        end
        last_hs_cyc = cyc;
      end
      if (tmo) begin
        to_seen++;
        chk("timeout_cycles_after_last_beat", cyc - last_hs_cyc, 9);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    arstn = 1'b0; req_en = 4'b1111;
    // Scenario 1: req0 sends 41,42,43 with sources already valid during reset.
    src(0, 8'h41, 0, 0); src(0, 8'h42, 0, 0); src(0, 8'h43, 1, 0);
    expb(0, 8'h41, 0); expb(0, 8'h42, 0); expb(0, 8'h43, 1);
    step(3);
    chk("rst_src_vld_driven", s_tvalid[0], 1);
    chk("rst_s_tready", s_tready, 0);
    chk("rst_m_tvalid", m_tvalid, 0);
    chk("rst_m_tdata", m_tdata, 0);
    chk("rst_m_tid", m_tid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_timeout", tmo, 0);
    arstn = 1'b1;
    drain("sc1");

    // Scenario 2a: req1 then req3 (last_grant=0).
    src(1, 8'h21, 0, 0); src(1, 8'h22, 1, 0);
    src(3, 8'h23, 0, 0); src(3, 8'h24, 1, 0);
    expb(1, 8'h21, 0); expb(1, 8'h22, 1); expb(3, 8'h23, 0); expb(3, 8'h24, 1);
    drain("sc2a");
    // Scenario 2b: last_grant=3 wraps to 0, then 1, then 3.
    src(0, 8'h30, 1, 0); src(1, 8'h31, 1, 0); src(3, 8'h33, 1, 0);
    expb(0, 8'h30, 1); expb(1, 8'h31, 1); expb(3, 8'h33, 1);
    drain("sc2b");

    // Scenario 3: m_tready toggling during a 4-byte packet.
    tog = 1'b1;
    for (int i = 0; i < 4; i++) begin
      src(1, 8'h10 + 8'(i), (i == 3), 0);
      expb(1, 8'h10 + 8'(i), (i == 3));
    end
    drain("sc3");
    tog = 1'b0;
    chk("timeouts_before_sc4", to_seen, 0);

    // Scenario 4a: req2 stalls mid-packet, gets evicted, req0 runs, req2 finishes later.
    src(2, 8'h60, 0, 0); src(2, 8'h61, 1, 12);
    src(0, 8'h62, 1, 3);
    expb(2, 8'h60, 0); expb(0, 8'h62, 1); expb(2, 8'h61, 1);
    drain("sc4a");
    chk("sc4a_timeouts", to_seen, 1);
`ifdef UART_TX_ARB_STATS_EN
    chk("stat_bytes0", stat_bytes[0*32 +: 32], 5);
    chk("stat_bytes1", stat_bytes[1*32 +: 32], 7);
    chk("stat_bytes2", stat_bytes[2*32 +: 32], 2);
    chk("stat_bytes3", stat_bytes[3*32 +: 32], 3);
    chk("stat_timeouts2", stat_tos[2*16 +: 16], 1);
    chk("stat_timeouts0", stat_tos[0*16 +: 16], 0);
`endif
    // Scenario 4b: valid returns on the 8th stalled cycle, no eviction.
    src(2, 8'h70, 0, 0); src(2, 8'h71, 1, 7);
    expb(2, 8'h70, 0); expb(2, 8'h71, 1);
    drain("sc4b");
    chk("sc4b_timeouts", to_seen, 1);

    // Scenario 5: req1 masked; holder req3 loses its enable mid-packet yet completes.
    req_en = 4'b1101;
    src(0, 8'h50, 1, 0); src(1, 8'h51, 1, 0); src(2, 8'h52, 1, 0);
    src(3, 8'h53, 0, 0); src(3, 8'h54, 1, 4);
    expb(3, 8'h53, 0); expb(3, 8'h54, 1); expb(0, 8'h50, 1); expb(2, 8'h52, 1);
    n = 0;
    while (!(busy && m_tid == 2'd3) && n < 100) begin step(1); n++; end
    chk("sc5_req3_granted", (busy && m_tid == 2'd3), 1);
    req_en = 4'b0101;
    drain("sc5");
    chk("sc5_req1_still_pending", s_tvalid[1], 1);
    req_en = 4'b1111;
    expb(1, 8'h51, 1);
    drain("sc5_req1");
    chk("final_timeouts", to_seen, 1);
`ifdef UART_TX_ARB_STATS_EN
    chk("stat_bytes0_end", stat_bytes[0*32 +: 32], 6);
    chk("stat_bytes1_end", stat_bytes[1*32 +: 32], 8);
    chk("stat_bytes2_end", stat_bytes[2*32 +: 32], 5);
    chk("stat_bytes3_end", stat_bytes[3*32 +: 32], 5);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
